// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline control for the 5-stage Y86-64 core.
// Produces per-stage stall/bubble controls for the F/D/E/M/W registers.
// Detects load/use, ret, mispredict and data-memory-wait hazards.
// Sequences exception drain and halt, and keeps saturating performance counters.
// Ports:
//   clk, rst_n (synchronous, active-low)
//   D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_cnd, M_icode, m_stat,
//   W_icode, W_stat, dmem_busy                          : pipeline observations
//   *_stall / *_bubble / set_cc_en                      : combinational controls
//   halted, stat_out, *_cnt                             : registered status and counters
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_W    = 32,
  parameter logic [3:0]  STAT_AOK = 4'd1,
  parameter logic [3:0]  STAT_HLT = 4'd2,
  parameter logic [3:0]  STAT_ADR = 4'd3,
  parameter logic [3:0]  STAT_INS = 4'd4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_cnd,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_icode,
  input  logic [3:0]       W_stat,
  input  logic             dmem_busy,
  output logic             F_stall,
  output logic             D_stall,
  output logic             E_stall,
  output logic             M_stall,
  output logic             W_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_bubble,
  output logic             set_cc_en,
  output logic             halted,
  output logic [3:0]       stat_out,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] REG_NONE = 4'hF;

  // Halt detection relies on every fault code differing from the normal code.
  if (STAT_HLT == STAT_AOK || STAT_ADR == STAT_AOK || STAT_INS == STAT_AOK) begin : g_stat_check
    $error("pipe_hazard_ctrl: fault status codes must differ from STAT_AOK");
  end

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_e;

  state_e           state_q, state_d;
  logic             halted_q, halted_d;
  logic [3:0]       stat_out_q, stat_out_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic [CNT_W-1:0] retire_q, retire_d;

  logic lu_c, rt_c, mp_c, ex_c, m_err_c, w_err_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != '1)) return v + CNT_W'(1);
    return v;
  endfunction

  // Hazard terms.
  always_comb begin
    m_err_c = (m_stat != STAT_AOK);
    w_err_c = (W_stat != STAT_AOK);
    ex_c    = m_err_c | w_err_c;
    lu_c    = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != REG_NONE) &&
              ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    rt_c    = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    mp_c    = (E_icode == I_JXX) && !e_cnd;
  end

  // Stage controls: reset flush, halt freeze, memory wait, then hazard rules.
  always_comb begin
    F_stall   = 1'b0;
    D_stall   = 1'b0;
    E_stall   = 1'b0;
    M_stall   = 1'b0;
    W_stall   = 1'b0;
    D_bubble  = 1'b0;
    E_bubble  = 1'b0;
    M_bubble  = 1'b0;
    W_bubble  = 1'b0;
    set_cc_en = 1'b0;
    if (!rst_n) begin
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      W_bubble = 1'b1;
    end else if (state_q == S_HALTED) begin
      F_stall = 1'b1;
      D_stall = 1'b1;
      E_stall = 1'b1;
      M_stall = 1'b1;
      W_stall = 1'b1;
    end else if (dmem_busy) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      E_stall  = 1'b1;
      M_stall  = 1'b1;
      W_bubble = 1'b1;
    end else begin
      F_stall   = lu_c | rt_c;
      D_stall   = lu_c;
      // A stalled D register must not also take a bubble.
      D_bubble  = (mp_c | (rt_c & ~lu_c)) & ~lu_c;
      E_bubble  = mp_c | lu_c;
      M_bubble  = ex_c;
      W_stall   = w_err_c;
      set_cc_en = (E_icode == I_OPQ) && !ex_c && (state_q == S_RUN);
    end
  end

  // Status FSM and counters; everything freezes once halted.
  always_comb begin
    state_d    = state_q;
    halted_d   = halted_q;
    stat_out_d = stat_out_q;
    cycle_d    = cycle_q;
    stall_d    = stall_q;
    bubble_d   = bubble_q;
    retire_d   = retire_q;
    if (state_q != S_HALTED) begin
      cycle_d  = sat_inc(cycle_q, 1'b1);
      stall_d  = sat_inc(stall_q, F_stall);
      bubble_d = sat_inc(bubble_q, E_bubble);
      retire_d = sat_inc(retire_q, (W_icode != I_NOP) && !w_err_c && !W_stall);
      case (state_q)
        S_RUN: begin
          if (w_err_c)      state_d = S_HALTED;
          else if (m_err_c) state_d = S_DRAIN;
        end
        S_DRAIN: begin
          if (w_err_c) state_d = S_HALTED;
        end
        default: state_d = state_q;
      endcase
      if (state_d == S_HALTED) begin
        halted_d   = 1'b1;
        stat_out_d = W_stat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      halted_q   <= 1'b0;
      stat_out_q <= STAT_AOK;
      cycle_q    <= '0;
      stall_q    <= '0;
      bubble_q   <= '0;
      retire_q   <= '0;
    end else begin
      state_q    <= state_d;
      halted_q   <= halted_d;
      stat_out_q <= stat_out_d;
      cycle_q    <= cycle_d;
      stall_q    <= stall_d;
      bubble_q   <= bubble_d;
      retire_q   <= retire_d;
    end
  end

  assign halted     = halted_q;
  assign stat_out   = stat_out_q;
  assign cycle_cnt  = cycle_q;
  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
  assign retire_cnt = retire_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage Y86-64 core.
- Generates per-stage stall/bubble controls for the F, D, E, M and W pipeline registers (the M register consumes M_bubble).
- Detects load/use hazards, ret hazards, mispredicted jumps and multi-cycle data-memory waits.
- Sequences exception drain and halt with a status FSM, and keeps saturating performance counters.

Parameters:
CNT_W, 32, width of each performance counter
STAT_AOK, 1, status code: normal
STAT_HLT, 2, status code: halt executed
STAT_ADR, 3, status code: bad address
STAT_INS, 4, status code: illegal instruction

Ports:
clk  in  1  core clock
rst_n  in  1  reset
D_icode  in  4  icode in Decode
d_srcA  in  4  Decode source A (0xF = none)
d_srcB  in  4  Decode source B (0xF = none)
E_icode  in  4  icode in Execute
E_dstM  in  4  Execute load destination
e_cnd  in  1  branch condition computed in Execute
M_icode  in  4  icode in Memory
m_stat  in  4  status leaving Memory stage
W_icode  in  4  icode in Writeback
W_stat  in  4  status in Writeback
dmem_busy  in  1  data memory access outstanding this cycle
F_stall, D_stall, E_stall, M_stall, W_stall  out  1 each  hold stage register
D_bubble, E_bubble, M_bubble, W_bubble  out  1 each  load nop (icode 1, dst 0xF) into stage register
set_cc_en  out  1  condition-code write enable
halted  out  1  core halted
stat_out  out  4  architectural status
cycle_cnt, stall_cnt, bubble_cnt, retire_cnt  out  CNT_W each  performance counters

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at posedge): state <= RUN, all counters <= 0, stat_out <= STAT_AOK, halted <= 0.
- While rst_n=0, the combinational outputs are forced: all bubbles=1, all stalls=0, set_cc_en=0. This flushes the un-reset pipeline registers to nops.
- icodes: HALT=0, NOP=1, OPQ=6, JXX=7, RET=9, MRMOVQ=5, POPQ=0xB.
- Hazard terms, all combinational:
  - LU (load/use) = E_icode in {MRMOVQ, POPQ} and E_dstM != 0xF and E_dstM in {d_srcA, d_srcB}.
  - RT (ret in flight) = RET in {D_icode, E_icode, M_icode}.
  - MP (mispredicted jump) = E_icode==JXX and e_cnd==0.
  - EX (exception in M or W) = m_stat!=AOK or W_stat!=AOK.
- Output priority in RUN/DRAIN, highest first:
  1. dmem_busy: F/D/E/M_stall=1, W_bubble=1, all other bubbles=0.
  2. Otherwise:
     - F_stall = LU | RT.
     - D_stall = LU.
     - D_bubble = MP | (RT & ~LU).
     - E_bubble = MP | LU.
     - M_bubble = EX.
     - W_stall = (W_stat!=AOK).
     - E_stall = M_stall = W_bubble = 0.
- A stage never sees stall and bubble together; stall wins.
- set_cc_en = (E_icode==OPQ) & ~EX & ~dmem_busy & (state==RUN).
- FSM states: RUN, DRAIN, HALTED.
  - RUN -> HALTED if W_stat!=AOK. RUN -> DRAIN if m_stat!=AOK.
  - DRAIN -> HALTED when W_stat!=AOK.
  - HALTED is sticky until reset.
- On entry to HALTED: stat_out <= W_stat and halted <= 1. These outputs are registered, so they show one cycle after W_stat!=AOK is seen.
- In HALTED: all five stalls=1, all bubbles=0, set_cc_en=0.
- Counters increment only in RUN/DRAIN, saturate at all-ones, and are frozen in HALTED:
  - cycle_cnt: +1 every cycle.
  - stall_cnt: +1 when F_stall=1.
  - bubble_cnt: +1 when E_bubble=1.
  - retire_cnt: +1 when W_icode!=NOP, W_stat==AOK and W_stall=0.
- Reset mid-operation overrides everything in the same edge.

Test Plan:
- Load/use: E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; stall_cnt and bubble_cnt each +1.
- Ret: D_icode=9 for 3 cycles with no LU -> F_stall=1 and D_bubble=1 each cycle; then all clear; stall_cnt=3.
- Mispredict: E_icode=7, e_cnd=0, plus D_icode=9 -> D_bubble=1, E_bubble=1, F_stall=1, set_cc_en=0.
- dmem_busy=1 for 4 cycles during LU -> F/D/E/M_stall=1, W_bubble=1, E_bubble=0; cycle_cnt +4, retire_cnt +0.
- Exception: m_stat=3 -> M_bubble=1, set_cc_en=0 for an OPQ in E, FSM in DRAIN. Next cycle W_stat=3 -> W_stall=1; following cycle halted=1, stat_out=3, all stalls=1, counters frozen. rst_n=0 for one edge -> halted=0, counters=0, stat_out=1.
- Saturation: preload via long run with CNT_W=4 -> cycle_cnt holds at 15.
